// File: rtl/spi_bus_arbiter.sv
// Two-requester SPI pad arbiter (requester 0 = flash, requester 1 = RAM) with hold timeout and inter-grant gap.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 wins simultaneous requests.
module spi_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  input  logic r0_clk,
  input  logic r0_mosi,
  input  logic r0_cs_n,
  input  logic r1_clk,
  input  logic r1_mosi,
  input  logic r1_cs_n,
  output logic r0_miso,
  output logic r1_miso,
  output logic spi_clk,
  output logic spi_mosi,
  input  logic spi_miso,
  output logic spi_cs_n_flash,
  output logic spi_cs_n_ram,
  output logic timeout
);

  // IDLE: arbitrate | GNT0/GNT1: pads owned by requester | GAP: both chip selects forced high
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;

  localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t      state;
  logic [15:0] hold_cnt;
  logic [3:0]  gap_cnt;
  logic        lock0;
  logic        lock1;
  logic        elig0;
  logic        elig1;
  logic        pick1;
  logic        rel0;
  logic        rel1;
  logic        hold_max;

  // A requester revoked by timeout stays locked out until it drops its request.
  assign elig0    = req0 & ~lock0;
  assign elig1    = req1 & ~lock1;
  assign rel0     = ~req0 & r0_cs_n;
  assign rel1     = ~req1 & r1_cs_n;
  assign hold_max = (hold_cnt == HOLD_LAST);

`ifdef SPI_ARB_ROUND_ROBIN_EN
  logic last1;
  assign pick1 = elig1 & (~elig0 | ~last1);
`else
  assign pick1 = elig1 & ~elig0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      lock0    <= 1'b0;
      lock1    <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      last1    <= 1'b1;
`endif
    end else begin
      timeout <= 1'b0;
      if (!req0) lock0 <= 1'b0;
      if (!req1) lock1 <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            hold_cnt <= '0;
            if (pick1) begin
              state <= GNT1;
              gnt1  <= 1'b1;
            end else begin
              state <= GNT0;
              gnt0  <= 1'b1;
            end
`ifdef SPI_ARB_ROUND_ROBIN_EN
            last1 <= pick1;
`endif
          end
        end
        GNT0: begin
          hold_cnt <= hold_cnt + 16'd1;
          if (rel0 || hold_max) begin
            state   <= GAP;
            gnt0    <= 1'b0;
            gap_cnt <= GAP_LAST;
            if (!rel0) begin
              timeout <= 1'b1;
              lock0   <= req0;
            end
          end
        end
        GNT1: begin
          hold_cnt <= hold_cnt + 16'd1;
          if (rel1 || hold_max) begin
            state   <= GAP;
            gnt1    <= 1'b0;
            gap_cnt <= GAP_LAST;
            if (!rel1) begin
              timeout <= 1'b1;
              lock1   <= req1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) state <= IDLE;
          else gap_cnt <= gap_cnt - 4'd1;
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
        end
      endcase
    end
  end

  // Pad mux is gated by the registered grants so a chip select can never leak outside its grant.
  assign spi_clk        = (gnt0 & r0_clk) | (gnt1 & r1_clk);
  assign spi_mosi       = (gnt0 & r0_mosi) | (gnt1 & r1_mosi);
  assign spi_cs_n_flash = ~gnt0 | r0_cs_n;
  assign spi_cs_n_ram   = ~gnt1 | r1_cs_n;
  assign r0_miso        = gnt0 & spi_miso;
  assign r1_miso        = gnt1 & spi_miso;

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, max cycles one grant may be held before forced release; legal range 2..65535.
REQ-002 Parameter GAP_CYCLES, default 1, idle cycles with both chip selects high between grants; legal range 1..15.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0  in  1  flash requester wants the bus (level).
REQ-006 req1  in  1  RAM requester wants the bus (level).
REQ-007 gnt0, gnt1  out  1 each  registered grant to requester 0 / 1.
REQ-008 r0_clk, r0_mosi, r0_cs_n  in  1 each  requester 0 SPI drive.
REQ-009 r1_clk, r1_mosi, r1_cs_n  in  1 each  requester 1 SPI drive.
REQ-010 r0_miso, r1_miso  out  1 each  MISO returned to each requester.
REQ-011 spi_clk, spi_mosi  out  1 each  shared pad SPI clock and data out.
REQ-012 spi_miso  in  1  shared pad SPI data in.
REQ-013 spi_cs_n_flash, spi_cs_n_ram  out  1 each  pad chip selects, active low.
REQ-014 timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-015 States: IDLE, GNT0, GNT1, GAP; gnt0 = (state==GNT0), gnt1 = (state==GNT1), both registered.
REQ-016 Handshake: requester raises reqN, waits for gntN, only then drives rN_cs_n low; on completion raises rN_cs_n, then drops reqN.
REQ-017 IDLE: req0 only -> GNT0; req1 only -> GNT1; both -> per REQ-029/030; neither -> IDLE; grant visible the cycle after the request is sampled.
REQ-018 GNTn -> GAP when reqN is sampled low and rN_cs_n is sampled high in the same cycle.
REQ-019 GAP lasts exactly GAP_CYCLES cycles, then IDLE; requests are not evaluated during GAP.
REQ-020 Minimum request-to-grant latency 1 cycle; back-to-back grants separated by GAP_CYCLES+1 cycles with both gnt low.
REQ-021 Pad mux: spi_clk/spi_mosi = granted requester's rN_clk/rN_mosi; 0 when no grant.
REQ-022 spi_cs_n_flash = r0_cs_n in GNT0, else 1; spi_cs_n_ram = r1_cs_n in GNT1, else 1; never both low.
REQ-023 rN_miso = spi_miso while gntN, else 0.
REQ-024 16-bit hold counter clears on entry to GNTn and increments each GNTn cycle; reaching TIMEOUT_CYCLES-1 forces GAP and pulses timeout one cycle.
REQ-025 After forced revoke, the revoked requester's reqN must drop low before it can be granted again; held-high reqN is ignored meanwhile.
REQ-026 reqN deasserted while rN_cs_n still low: grant held until cs_n high (or timeout).
REQ-027 reqN dropped before grant issued: no grant; arbiter stays IDLE.

Reset
REQ-028 reset: state IDLE, gnt0=gnt1=0, timeout=0, counters 0, spi_cs_n_flash=spi_cs_n_ram=1, spi_clk=spi_mosi=0, r0_miso=r1_miso=0, last-winner=requester 1, revoke locks cleared; reset mid-grant aborts immediately in the next cycle.

Configuration
REQ-029 Macro SPI_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant goes to the requester not granted last.
REQ-030 Macro undefined: fixed priority, requester 0 (flash) always wins simultaneous requests; last-winner register not implemented.

Verification
REQ-031 req0=1 alone from IDLE -> gnt0=1 next cycle; r0_cs_n low 8 cycles toggling r0_clk -> spi_cs_n_flash tracks r0_cs_n, spi_cs_n_ram=1, spi_clk follows r0_clk.
REQ-032 req0 and req1 rise same cycle after reset -> gnt0 first; after release and 1 gap cycle, gnt1; with SPI_ARB_ROUND_ROBIN_EN a second simultaneous pair -> gnt0 again, without it -> gnt0 again only (gnt1 starves while req0 reasserted).
REQ-033 TIMEOUT_CYCLES=16, req1 held with r1_cs_n low -> gnt1 drops after 16 cycles, timeout=1 for exactly one cycle, spi_cs_n_ram=1; req1 held high -> no regrant until req1 toggles.
REQ-034 spi_miso driven 1 during GNT1 -> r1_miso=1, r0_miso=0; after release both 0.
REQ-035 reset asserted mid-GNT0 -> next cycle gnt0=0, spi_cs_n_flash=1, state IDLE; reset released with req1=1 -> gnt1 one cycle later.
REQ-036 req0 dropped while r0_cs_n low -> gnt0 held until r0_cs_n high, then GAP_CYCLES cycles all chip selects high.
